// File: rtl/mult_issue_ctrl_pkg.sv
// Shared system defines for the multiplier issue path:
// credit pool size, tag widths and the bundles that travel with products.
package mult_issue_ctrl_pkg;

    localparam int SYS_CMPL_DEPTH = 4;
    localparam int SYS_MULT_LAT   = 4;
    localparam int PR_W           = 7;
    localparam int AR_W           = 5;
    localparam int XLEN           = 64;

    typedef struct packed {
        logic            valid;
        logic [PR_W-1:0] pr;
        logic [AR_W-1:0] ar;
    } mult_tag_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [PR_W-1:0] pr;
        logic [AR_W-1:0] ar;
    } cmpl_entry_t;

    // Issue permission mask from the number of free credits.
    function automatic logic [1:0] avail_mask(input logic [7:0] free);
        if (free >= 8'd2) begin
            return 2'b11;
        end else if (free == 8'd1) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

endpackage

// File: rtl/mult.sv
// Four-stage pipelined 64x64 multiplier (low 64 bits of the product).
// One 16-bit slice of the multiplier is folded into the sum per stage.
module mult
    import mult_issue_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    output logic [XLEN-1:0] product,
    output logic            done
);

    localparam int STAGES = 4;
    localparam int SLICE  = XLEN / STAGES;

    logic [STAGES-1:0] vld;
    logic [XLEN-1:0]   acc [STAGES];
    logic [XLEN-1:0]   mc  [STAGES-1];
    logic [XLEN-1:0]   mp  [STAGES-1];

    // Stage valid flags; reset drops every operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
        end else begin
            vld <= {vld[STAGES-2:0], start};
        end
    end

    // Datapath: multiplicand shifts left and multiplier right each stage,
    // so every stage multiplies by the low slice only.
    always_ff @(posedge clock) begin
        acc[0] <= mcand * XLEN'(mplier[SLICE-1:0]);
        mc[0]  <= mcand << SLICE;
        mp[0]  <= mplier >> SLICE;
        for (int i = 1; i < STAGES; i++) begin
            acc[i] <= acc[i-1] + mc[i-1] * XLEN'(mp[i-1][SLICE-1:0]);
        end
        for (int i = 1; i < STAGES - 1; i++) begin
            mc[i] <= mc[i-1] << SLICE;
            mp[i] <= mp[i-1] >> SLICE;
        end
    end

    assign product = acc[STAGES-1];
    assign done    = vld[STAGES-1];

endmodule

// File: rtl/mult_cmpl_buf.sv
// In-order completion buffer: two writes (lane 0 older) and two reads
// (head, head+1) per cycle, with an occupancy count.
module mult_cmpl_buf
    import mult_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = SYS_CMPL_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic            clock,
    input  logic            reset,
    input  logic            push0,
    input  logic [XLEN-1:0] wr_result0,
    input  logic [PR_W-1:0] wr_pr0,
    input  logic [AR_W-1:0] wr_ar0,
    input  logic            push1,
    input  logic [XLEN-1:0] wr_result1,
    input  logic [PR_W-1:0] wr_pr1,
    input  logic [AR_W-1:0] wr_ar1,
    input  logic            pop0,
    input  logic            pop1,
    output logic [XLEN-1:0] rd_result0,
    output logic [PR_W-1:0] rd_pr0,
    output logic [AR_W-1:0] rd_ar0,
    output logic [XLEN-1:0] rd_result1,
    output logic [PR_W-1:0] rd_pr1,
    output logic [AR_W-1:0] rd_ar1,
    output logic [CW-1:0]   count
);

    cmpl_entry_t     mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   head1;
    logic [PW-1:0]   wr_idx1;
    logic [CW-1:0]   n_push;
    logic [CW-1:0]   n_pop;
    cmpl_entry_t     ent0;
    cmpl_entry_t     ent1;

    assign n_push  = CW'(push0) + CW'(push1);
    assign n_pop   = CW'(pop0) + CW'(pop1);
    assign wr_idx1 = push0 ? tail + PW'(1) : tail;
    assign head1   = head + PW'(1);

    // Entry storage; lane 1 lands behind lane 0 when both finish together.
    always_ff @(posedge clock) begin
        if (push0) begin
            mem[tail] <= {wr_result0, wr_pr0, wr_ar0};
        end
        if (push1) begin
            mem[wr_idx1] <= {wr_result1, wr_pr1, wr_ar1};
        end
    end

    // Pointers and occupancy; power-of-two depth gives free wraparound.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(n_push);
            count <= count + n_push - n_pop;
        end
    end

    // Credits upstream must keep the buffer from overflowing or underflowing.
    always @(posedge clock) begin
        if (!reset) begin
            assert (32'(count) + 32'(n_push) <= 32'(DEPTH));
            assert (n_pop <= count);
        end
    end

    assign ent0       = mem[head];
    assign ent1       = mem[head1];
    assign rd_result0 = ent0.result;
    assign rd_pr0     = ent0.pr;
    assign rd_ar0     = ent0.ar;
    assign rd_result1 = ent1.result;
    assign rd_pr1     = ent1.pr;
    assign rd_ar1     = ent1.ar;

endmodule

// File: rtl/mult_issue_ctrl.sv
// Dual-lane multiply issue/completion controller: credit-gated issue into
// two pipelined multipliers, tags carried alongside, in-order CDB drain.
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int CMPL_DEPTH = SYS_CMPL_DEPTH,
    parameter int MULT_LAT   = SYS_MULT_LAT
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        rs_valid_inst0,
    input  logic        rs_valid_inst1,
    input  logic [63:0] prf_pra0,
    input  logic [63:0] prf_prb0,
    input  logic [63:0] prf_pra1,
    input  logic [63:0] prf_prb1,
    input  logic [6:0]  rs_dest_pr_idx0,
    input  logic [6:0]  rs_dest_pr_idx1,
    input  logic [4:0]  rs_dest_ar_idx0,
    input  logic [4:0]  rs_dest_ar_idx1,
    input  logic        cdb_grant0,
    input  logic        cdb_grant1,
    output logic [1:0]  rs_mult_avail,
    output logic        cdb_complete0,
    output logic        cdb_complete1,
    output logic [6:0]  cdb_prf_dest_pr_idx0,
    output logic [6:0]  cdb_prf_dest_pr_idx1,
    output logic [4:0]  cdb_dest_ar_idx0,
    output logic [4:0]  cdb_dest_ar_idx1,
    output logic [63:0] prf_result0,
    output logic [63:0] prf_result1,
    output logic        prf_write_enable0,
    output logic        prf_write_enable1
);

    localparam int CW = $clog2(CMPL_DEPTH + 1);

    logic [CW-1:0]   inflight;
    logic [CW-1:0]   free;
    logic [CW-1:0]   n_acc;
    logic [CW-1:0]   n_pop;
    logic [CW-1:0]   count;
    logic            accept0;
    logic            accept1;
    logic            pop0;
    logic            pop1;
    logic            done0;
    logic            done1;
    logic [63:0]     product0;
    logic [63:0]     product1;
    mult_tag_t       tag0 [MULT_LAT];
    mult_tag_t       tag1 [MULT_LAT];
    mult_tag_t       tail0;
    mult_tag_t       tail1;

    assign free          = CW'(CMPL_DEPTH) - inflight;
    assign rs_mult_avail = avail_mask(8'(free));

    // Lane 1 alone only needs a single credit.
    assign accept0 = rs_valid_inst0 & rs_mult_avail[0];
    assign accept1 = rs_valid_inst1 &
                     (rs_valid_inst0 ? rs_mult_avail[1]
                                     : rs_mult_avail[0]);

    assign n_acc = CW'(accept0) + CW'(accept1);
    assign n_pop = CW'(pop0) + CW'(pop1);

    // Credit counter: issued ops not yet popped onto the CDB.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            inflight <= inflight + n_acc - n_pop;
        end
    end

    // Destination tags ride a shift register matched to multiplier depth.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                tag0[i] <= '0;
                tag1[i] <= '0;
            end
        end else begin
            tag0[0] <= '{valid: accept0,
                         pr: rs_dest_pr_idx0,
                         ar: rs_dest_ar_idx0};
            tag1[0] <= '{valid: accept1,
                         pr: rs_dest_pr_idx1,
                         ar: rs_dest_ar_idx1};
            for (int i = 1; i < MULT_LAT; i++) begin
                tag0[i] <= tag0[i-1];
                tag1[i] <= tag1[i-1];
            end
        end
    end

    assign tail0 = tag0[MULT_LAT-1];
    assign tail1 = tag1[MULT_LAT-1];

    // Tag pipe and multiplier pipe must stay in lockstep.
    always @(posedge clock) begin
        if (!reset) begin
            assert (done0 == tail0.valid);
            assert (done1 == tail1.valid);
        end
    end

    mult u_mult0 (
        .clock   (clock),
        .reset   (reset),
        .start   (accept0),
        .mcand   (prf_pra0),
        .mplier  (prf_prb0),
        .product (product0),
        .done    (done0)
    );

    mult u_mult1 (
        .clock   (clock),
        .reset   (reset),
        .start   (accept1),
        .mcand   (prf_pra1),
        .mplier  (prf_prb1),
        .product (product1),
        .done    (done1)
    );

    mult_cmpl_buf #(.DEPTH(CMPL_DEPTH)) u_buf (
        .clock      (clock),
        .reset      (reset),
        .push0      (done0),
        .wr_result0 (product0),
        .wr_pr0     (tail0.pr),
        .wr_ar0     (tail0.ar),
        .push1      (done1),
        .wr_result1 (product1),
        .wr_pr1     (tail1.pr),
        .wr_ar1     (tail1.ar),
        .pop0       (pop0),
        .pop1       (pop1),
        .rd_result0 (prf_result0),
        .rd_pr0     (cdb_prf_dest_pr_idx0),
        .rd_ar0     (cdb_dest_ar_idx0),
        .rd_result1 (prf_result1),
        .rd_pr1     (cdb_prf_dest_pr_idx1),
        .rd_ar1     (cdb_dest_ar_idx1),
        .count      (count)
    );

    assign cdb_complete0 = (count >= CW'(1));
    assign cdb_complete1 = (count >= CW'(2));

    // Slot 1 may only drain together with slot 0 to keep order.
    assign pop0 = cdb_complete0 & cdb_grant0;
    assign pop1 = cdb_complete1 & cdb_grant1 & pop0;

    assign prf_write_enable0 = pop0;
    assign prf_write_enable1 = pop1;

endmodule
